// File: rtl/sfu_norm_round_if.sv
// sfu_norm_round_if: handshake and data bundle for the SFU normalize/round stage.
//   Upstream side : flush_i, valid_i, ready_o, sign_i, mant_i, exp_i, tag_i
//   Downstream side: valid_o, ready_i, result_o, tag_o, ovf_o, uf_o
// Signal suffixes are from the stage's point of view.
// slave  : used by the stage itself.
// master : used by whoever drives the stage and consumes its results.
interface sfu_norm_round_if #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned EXP_IN_WIDTH = 10,
  parameter int unsigned EXP_BITS     = 5,
  parameter int unsigned MAN_BITS     = 10,
  parameter int unsigned TAG_WIDTH    = 4
);
  logic                         flush_i;
  logic                         valid_i;
  logic                         ready_o;
  logic                         sign_i;
  logic [WIDTH-1:0]             mant_i;
  logic [EXP_IN_WIDTH-1:0]      exp_i;
  logic [TAG_WIDTH-1:0]         tag_i;
  logic                         valid_o;
  logic                         ready_i;
  logic [EXP_BITS+MAN_BITS:0]   result_o;
  logic [TAG_WIDTH-1:0]         tag_o;
  logic                         ovf_o;
  logic                         uf_o;

  modport slave (
    input  flush_i, valid_i, sign_i, mant_i, exp_i, tag_i, ready_i,
    output ready_o, valid_o, result_o, tag_o, ovf_o, uf_o
  );

  modport master (
    output flush_i, valid_i, sign_i, mant_i, exp_i, tag_i, ready_i,
    input  ready_o, valid_o, result_o, tag_o, ovf_o, uf_o
  );
endinterface

// File: rtl/sfu_norm_round.sv
// sfu_norm_round: two-stage normalize-and-round stage of the SFU datapath.
// Converts sign * mant * 2^exp into a packed {sign, exponent, fraction} float with
// round-to-nearest-even, saturating to infinity on overflow and flushing to zero on
// underflow (no subnormals).
// Ports:
//   clk_i - clock
//   rst_i - asynchronous active-high reset
//   bus   - slave side of sfu_norm_round_if (input handshake + operand, output
//           handshake + result, tag and ovf/uf flags)
module sfu_norm_round #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned EXP_IN_WIDTH = 10,
  parameter int unsigned EXP_BITS     = 5,
  parameter int unsigned MAN_BITS     = 10,
  parameter int unsigned BIAS         = 15,
  parameter int unsigned TAG_WIDTH    = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  sfu_norm_round_if.slave bus
);

  localparam int unsigned LzW    = $clog2(WIDTH);
  localparam int unsigned EW     = EXP_IN_WIDTH + 2;
  localparam int unsigned LoBits = WIDTH - 2 - MAN_BITS;
  localparam int unsigned ResW   = 1 + EXP_BITS + MAN_BITS;

  localparam logic signed [EW-1:0] BeOne = EW'(1);
  localparam logic signed [EW-1:0] BeMax = EW'((1 << EXP_BITS) - 1);
  localparam logic [WIDTH-1:0]     LoMask = (WIDTH'(1) << LoBits) - WIDTH'(1);

  // Handshake
  logic w_s2_load, w_s1_adv, w_s1_load, w_in_fire;

  // Stage 1 combinational
  logic [LzW-1:0]          w_lz;
  logic [WIDTH-1:0]        w_norm;
  logic signed [EW-1:0]    w_exp_ext;
  logic signed [EW-1:0]    w_be;
  logic                    w_zero;

  // Stage 1 registers
  logic                    r_s1_valid;
  logic                    r_sign;
  logic [TAG_WIDTH-1:0]    r_tag1;
  logic [WIDTH-1:0]        r_norm;
  logic signed [EW-1:0]    r_be;
  logic                    r_zero;

  // Stage 2 combinational
  logic [MAN_BITS-1:0]     w_frac;
  logic                    w_guard, w_sticky, w_round_up;
  logic [MAN_BITS:0]       w_frac_sum;
  logic signed [EW-1:0]    w_be_rnd;
  logic [ResW-1:0]         w_res;
  logic                    w_ovf, w_uf;

  // Stage 2 registers
  logic                    r_s2_valid;
  logic [ResW-1:0]         r_result;
  logic [TAG_WIDTH-1:0]    r_tag2;
  logic                    r_ovf, r_uf;

  assign w_s2_load   = ~r_s2_valid | bus.ready_i;
  assign w_s1_adv    = r_s1_valid & w_s2_load;
  assign w_s1_load   = ~bus.flush_i & (~r_s1_valid | w_s1_adv);
  assign w_in_fire   = bus.valid_i & w_s1_load;
  assign bus.ready_o = w_s1_load;

  // Leading-zero count, MSB-first scan (first set bit wins).
  always_comb begin
    logic found;
    found = 1'b0;
    w_lz  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && bus.mant_i[i]) begin
        w_lz  = LzW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign w_norm    = bus.mant_i << w_lz;
  // A normalized non-zero value always has its MSB set, so this equals mant_i == 0.
  assign w_zero    = ~w_norm[WIDTH-1];
  assign w_exp_ext = EW'($signed(bus.exp_i));
  assign w_be      = w_exp_ext + EW'(WIDTH - 1) - EW'(w_lz) + EW'(BIAS);

  // Rounding: bit WIDTH-1 is the hidden one, then fraction, guard, sticky.
  always_comb begin
    w_frac     = r_norm[WIDTH-2 -: MAN_BITS];
    w_guard    = r_norm[LoBits];
    w_sticky   = |(r_norm & LoMask);
    w_round_up = w_guard & (w_sticky | w_frac[0]);
    w_frac_sum = {1'b0, w_frac} + {{MAN_BITS{1'b0}}, w_round_up};
    // On carry-out the low bits are already zero; only the exponent bumps.
    w_be_rnd   = r_be + EW'(w_frac_sum[MAN_BITS]);

    w_res = '0;
    w_ovf = 1'b0;
    w_uf  = 1'b0;
    if (r_zero) begin
      w_res = {r_sign, {(EXP_BITS + MAN_BITS){1'b0}}};
    end else if (r_be < BeOne) begin
      w_res = {r_sign, {(EXP_BITS + MAN_BITS){1'b0}}};
      w_uf  = 1'b1;
    end else if (w_be_rnd >= BeMax) begin
      w_res = {r_sign, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
      w_ovf = 1'b1;
    end else begin
      w_res = {r_sign, w_be_rnd[EXP_BITS-1:0], w_frac_sum[MAN_BITS-1:0]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_sign     <= 1'b0;
      r_tag1     <= '0;
      r_norm     <= '0;
      r_be       <= '0;
      r_zero     <= 1'b0;
      r_result   <= '0;
      r_tag2     <= '0;
      r_ovf      <= 1'b0;
      r_uf       <= 1'b0;
    end else begin
      if (bus.flush_i) begin
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
      end else begin
        if (w_s1_load) r_s1_valid <= bus.valid_i;
        if (w_s2_load) r_s2_valid <= r_s1_valid;
      end
      if (w_in_fire) begin
        r_sign <= bus.sign_i;
        r_tag1 <= bus.tag_i;
        r_norm <= w_norm;
        r_be   <= w_be;
        r_zero <= w_zero;
      end
      if (w_s1_adv) begin
        r_result <= w_res;
        r_tag2   <= r_tag1;
        r_ovf    <= w_ovf;
        r_uf     <= w_uf;
      end
    end
  end

  assign bus.valid_o  = r_s2_valid;
  assign bus.result_o = r_result;
  assign bus.tag_o    = r_tag2;
  // Flags are qualified so a bubble never shows a stale flag.
  assign bus.ovf_o    = r_ovf & r_s2_valid;
  assign bus.uf_o     = r_uf & r_s2_valid;

endmodule

// File: tb/tb_sfu_norm_round.sv
module tb_sfu_norm_round;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sfu_norm_round_if bus ();

  sfu_norm_round dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with an empty pipeline and ready_i=1.
  task automatic run_vec(input string name, input logic s, input logic [31:0] m,
                         input logic [9:0] e, input logic [3:0] t,
                         input logic [15:0] exp_res, input logic exp_ovf, input logic exp_uf);
    bus.valid_i = 1'b1;
    bus.sign_i  = s;
    bus.mant_i  = m;
    bus.exp_i   = e;
    bus.tag_i   = t;
    #3;
    check({name, "_ready_o"}, 64'(bus.ready_o), 64'd1);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    check({name, "_valid_early"}, 64'(bus.valid_o), 64'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 64'(bus.valid_o), 64'd1);
    check({name, "_result"}, 64'(bus.result_o), 64'(exp_res));
    check({name, "_ovf"}, 64'(bus.ovf_o), 64'(exp_ovf));
    check({name, "_uf"}, 64'(bus.uf_o), 64'(exp_uf));
    check({name, "_tag"}, 64'(bus.tag_o), 64'(t));
    @(posedge clk); #1;
  endtask

  // Backpressure bookkeeping
  logic [15:0] bp_res [5];
  int          sent, rcvd, cyc, acc, emerged;
  logic        prev_stall, accepted;
  logic [15:0] prev_res;
  logic [3:0]  prev_tag;

  initial begin
    bp_res[0] = 16'h3C00;
    bp_res[1] = 16'h4000;
    bp_res[2] = 16'h4200;
    bp_res[3] = 16'h4400;
    bp_res[4] = 16'h4500;

    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.sign_i  = 1'b0;
    bus.mant_i  = '0;
    bus.exp_i   = '0;
    bus.tag_i   = '0;
    bus.ready_i = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", 64'(bus.valid_o), 64'd0);
    check("rst_result_o", 64'(bus.result_o), 64'd0);
    check("rst_tag_o", 64'(bus.tag_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready_o", 64'(bus.ready_o), 64'd1);

    // Directed values
    run_vec("one",      1'b0, 32'h0000_0001, 10'd0,       4'h1, 16'h3C00, 1'b0, 1'b0);
    run_vec("onehalf",  1'b0, 32'h0000_0003, 10'h3FF,     4'h2, 16'h3E00, 1'b0, 1'b0);
    run_vec("rnd_carry",1'b0, 32'h0000_0FFF, 10'd0,       4'h3, 16'h6C00, 1'b0, 1'b0);
    run_vec("rnd_tie",  1'b0, 32'h0000_0801, 10'd0,       4'h4, 16'h6800, 1'b0, 1'b0);
    run_vec("ovf",      1'b0, 32'h8000_0000, 10'd0,       4'h5, 16'h7C00, 1'b1, 1'b0);
    run_vec("uf",       1'b0, 32'h0000_0001, 10'h3F1,     4'h6, 16'h0000, 1'b0, 1'b1);
    run_vec("neg_zero", 1'b1, 32'h0000_0000, 10'd0,       4'h7, 16'h8000, 1'b0, 1'b0);
    run_vec("neg_val",  1'b1, 32'h0000_0005, 10'd0,       4'h8, 16'hC500, 1'b0, 1'b0);

    // Backpressure: 5 tagged ops with random ready_i
    sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0;
    while ((rcvd < 5) && (cyc < 200)) begin
      bus.ready_i = 1'($urandom_range(0, 1));
      if (sent < 5) begin
        bus.valid_i = 1'b1;
        bus.sign_i  = 1'b0;
        bus.mant_i  = 32'(sent + 1);
        bus.exp_i   = '0;
        bus.tag_i   = 4'(sent + 3);
      end else begin
        bus.valid_i = 1'b0;
      end
      #3;
      if (prev_stall) begin
        check("bp_hold_valid", 64'(bus.valid_o), 64'd1);
        check("bp_hold_result", 64'(bus.result_o), 64'(prev_res));
        check("bp_hold_tag", 64'(bus.tag_o), 64'(prev_tag));
      end
      if (bus.valid_o && bus.ready_i) begin
        check("bp_tag", 64'(bus.tag_o), 64'(rcvd + 3));
        check("bp_result", 64'(bus.result_o), 64'(bp_res[rcvd]));
        rcvd++;
      end
      prev_stall = bus.valid_o & ~bus.ready_i;
      prev_res   = bus.result_o;
      prev_tag   = bus.tag_o;
      accepted   = bus.valid_i & bus.ready_o;
      @(posedge clk); #1;
      if (accepted) sent++;
      cyc++;
    end
    check("bp_received", 64'(rcvd), 64'd5);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    emerged = 0;
    repeat (3) begin
      #3;
      if (bus.valid_o) emerged++;
      @(posedge clk); #1;
    end
    check("bp_no_dup", 64'(emerged), 64'd0);

    // ready_i held low: exactly two accepts, then ready_o drops
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.sign_i  = 1'b0;
    bus.mant_i  = 32'h8000_0000;
    bus.exp_i   = '0;
    bus.tag_i   = 4'hA;
    acc = 0;
    repeat (4) begin
      #3;
      if (bus.valid_i && bus.ready_o) acc++;
      @(posedge clk); #1;
    end
    check("hold_accepts", 64'(acc), 64'd2);
    check("hold_ready_o", 64'(bus.ready_o), 64'd0);

    // Flush with both stages occupied
    bus.ready_i = 1'b1;
    bus.flush_i = 1'b1;
    #3;
    check("flush_ready_o", 64'(bus.ready_o), 64'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    emerged = 0;
    repeat (4) begin
      #3;
      if (bus.valid_o) emerged++;
      @(posedge clk); #1;
    end
    check("flush_none_emerge", 64'(emerged), 64'd0);

    // Asynchronous reset with both stages occupied
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.tag_i   = 4'hA;
    repeat (3) @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    check("prerst_valid_o", 64'(bus.valid_o), 64'd1);
    check("prerst_ovf_o", 64'(bus.ovf_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid_o", 64'(bus.valid_o), 64'd0);
    check("arst_result_o", 64'(bus.result_o), 64'd0);
    check("arst_tag_o", 64'(bus.tag_o), 64'd0);
    check("arst_ovf_o", 64'(bus.ovf_o), 64'd0);
    check("arst_uf_o", 64'(bus.uf_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    check("arst_drained", 64'(bus.valid_o), 64'd0);
    run_vec("after_rst", 1'b0, 32'h0000_0801, 10'd0, 4'hC, 16'h6800, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
